// File: rtl/ram_port_arbiter_if.sv
// Bus bundle for ram_port_arbiter: CPU port, DMA port and RAM-bank side.
// The slave modport is the arbiter's view; master is the surrounding system.
interface ram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cpu_req_i;
    logic [ADDR_WIDTH-1:0] cpu_addr_i;
    logic [DATA_WIDTH-1:0] cpu_data_i;
    logic [3:0]            cpu_we_i;
    logic                  cpu_stall_o;
    logic [DATA_WIDTH-1:0] cpu_data_o;

    logic                  dma_req_i;
    logic [ADDR_WIDTH-1:0] dma_addr_i;
    logic [DATA_WIDTH-1:0] dma_data_i;
    logic [3:0]            dma_we_i;
    logic                  dma_gnt_o;
    logic                  dma_ack_o;
    logic [DATA_WIDTH-1:0] dma_data_o;

    logic                  mem_cs_n_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [3:0]            mem_we_n_o;
    logic [DATA_WIDTH-1:0] mem_data_o;
    logic [DATA_WIDTH-1:0] mem_data_i;

    modport slave (
        input  cpu_req_i, cpu_addr_i, cpu_data_i, cpu_we_i,
        output cpu_stall_o, cpu_data_o,
        input  dma_req_i, dma_addr_i, dma_data_i, dma_we_i,
        output dma_gnt_o, dma_ack_o, dma_data_o,
        output mem_cs_n_o, mem_addr_o, mem_we_n_o, mem_data_o,
        input  mem_data_i
    );

    modport master (
        output cpu_req_i, cpu_addr_i, cpu_data_i, cpu_we_i,
        input  cpu_stall_o, cpu_data_o,
        output dma_req_i, dma_addr_i, dma_data_i, dma_we_i,
        input  dma_gnt_o, dma_ack_o, dma_data_o,
        input  mem_cs_n_o, mem_addr_o, mem_we_n_o, mem_data_o,
        output mem_data_i
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares the byte-banked single-port RAM between the CPU (default priority)
// and a DMA master, with a starvation timeout and a bounded DMA burst.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4,
    parameter int MAX_BURST  = 8
) (
    input logic              clk_i,
    input logic              rst_i,
    ram_port_arbiter_if.slave bus
);
    localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] ST_CPU = 1'b0;
    localparam logic [0:0] ST_DMA = 1'b1;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_DMA  = 2'd2;

    logic [0:0]            state_q;
    logic [WAIT_W-1:0]     wait_cnt_q;
    logic [BURST_W-1:0]    burst_cnt_q;
    logic [1:0]            owner_q;
    logic [DATA_WIDTH-1:0] cpu_data_q;
    logic                  dma_grant;
    logic                  cpu_grant;

    // Grants are suppressed during reset so nothing reaches the RAM and no ack follows.
    always_comb begin
        dma_grant = 1'b0;
        if (!rst_i && bus.dma_req_i) begin
            if (state_q == ST_DMA)
                dma_grant = !bus.cpu_req_i || (burst_cnt_q < BURST_W'(MAX_BURST));
            else
                dma_grant = !bus.cpu_req_i || (wait_cnt_q == WAIT_W'(MAX_WAIT));
        end
        cpu_grant = !rst_i && bus.cpu_req_i && !dma_grant;
    end

    always_comb begin
        bus.mem_cs_n_o = !(dma_grant || cpu_grant);
        bus.mem_addr_o = dma_grant ? bus.dma_addr_i : bus.cpu_addr_i;
        bus.mem_data_o = dma_grant ? bus.dma_data_i : bus.cpu_data_i;
        if (dma_grant)
            bus.mem_we_n_o = ~bus.dma_we_i;
        else if (cpu_grant)
            bus.mem_we_n_o = ~bus.cpu_we_i;
        else
            bus.mem_we_n_o = '1;
    end

    always_comb begin
        bus.cpu_stall_o = !rst_i && bus.cpu_req_i && !cpu_grant;
        bus.dma_gnt_o   = dma_grant;
        bus.dma_ack_o   = !rst_i && (owner_q == OWN_DMA);
        bus.dma_data_o  = bus.dma_ack_o ? bus.mem_data_i : '0;
        if (rst_i)
            bus.cpu_data_o = '0;
        else if (owner_q == OWN_CPU)
            bus.cpu_data_o = bus.mem_data_i;
        else
            bus.cpu_data_o = cpu_data_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_CPU;
            wait_cnt_q  <= '0;
            burst_cnt_q <= '0;
            owner_q     <= OWN_NONE;
            cpu_data_q  <= '0;
        end else begin
            if (dma_grant)
                owner_q <= OWN_DMA;
            else if (cpu_grant)
                owner_q <= OWN_CPU;
            else
                owner_q <= OWN_NONE;

            if (owner_q == OWN_CPU)
                cpu_data_q <= bus.mem_data_i;

            // Burst length only advances while the CPU is contending; otherwise it holds.
            if (dma_grant) begin
                state_q <= ST_DMA;
                if (bus.cpu_req_i) begin
                    if (state_q != ST_DMA)
                        burst_cnt_q <= BURST_W'(1);
                    else if (burst_cnt_q < BURST_W'(MAX_BURST))
                        burst_cnt_q <= burst_cnt_q + BURST_W'(1);
                end
            end else begin
                state_q     <= ST_CPU;
                burst_cnt_q <= '0;
            end

            if (bus.dma_req_i && !dma_grant) begin
                if (wait_cnt_q < WAIT_W'(MAX_WAIT))
                    wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
            end else begin
                wait_cnt_q <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a 1-cycle-latency byte-banked RAM model.
module tb_ram_port_arbiter;
    localparam logic [31:0] CPU_ADDR = 32'h4000_0010;
    localparam logic [31:0] DMA_ADDR = 32'h4000_0020;

    logic clk = 1'b0;
    logic rst;
    int   tests  = 0;
    int   errors = 0;
    logic [31:0] ram [0:63];
    logic [31:0] word;

    ram_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    ram_port_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MAX_WAIT  (4),
        .MAX_BURST (8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Read-before-write RAM; read data is zero when not selected so held CPU data is visible.
    always @(posedge clk) begin
        if (rst) begin
            ram[4]         <= 32'hDEAD_BEEF;
            ram[8]         <= 32'h1122_3344;
            bus.mem_data_i <= '0;
        end else if (!bus.mem_cs_n_o) begin
            bus.mem_data_i <= ram[bus.mem_addr_o[7:2]];
            for (int b = 0; b < 4; b++)
                if (!bus.mem_we_n_o[b])
                    ram[bus.mem_addr_o[7:2]][8*b +: 8] <= bus.mem_data_o[8*b +: 8];
        end else begin
            bus.mem_data_i <= '0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst            = 1'b1;
        bus.cpu_req_i  = 1'b1;
        bus.cpu_addr_i = CPU_ADDR;
        bus.cpu_data_i = '0;
        bus.cpu_we_i   = '0;
        bus.dma_req_i  = 1'b1;
        bus.dma_addr_i = DMA_ADDR;
        bus.dma_data_i = '0;
        bus.dma_we_i   = '0;

        // Reset with both requests pending
        next();
        chk("rst_cs_n",  32'(bus.mem_cs_n_o),  32'h1);
        chk("rst_we_n",  32'(bus.mem_we_n_o),  32'hF);
        chk("rst_stall", 32'(bus.cpu_stall_o), 32'h0);
        chk("rst_gnt",   32'(bus.dma_gnt_o),   32'h0);
        chk("rst_ack",   32'(bus.dma_ack_o),   32'h0);
        chk("rst_cdata", bus.cpu_data_o,       32'h0);
        chk("rst_ddata", bus.dma_data_o,       32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Cycle 0: CPU wins; DMA waits 4 cycles then is forced in
        #1;
        chk("c0_cs_n",  32'(bus.mem_cs_n_o),  32'h0);
        chk("c0_addr",  bus.mem_addr_o,       CPU_ADDR);
        chk("c0_stall", 32'(bus.cpu_stall_o), 32'h0);
        chk("c0_gnt",   32'(bus.dma_gnt_o),   32'h0);
        for (int c = 1; c <= 3; c++) begin
            next();
            chk("starve_cpu_gnt", 32'(bus.dma_gnt_o),   32'h0);
            chk("starve_cpu_stl", 32'(bus.cpu_stall_o), 32'h0);
        end
        chk("c3_cdata", bus.cpu_data_o, 32'hDEAD_BEEF);
        next();
        chk("c4_gnt",   32'(bus.dma_gnt_o),   32'h1);
        chk("c4_stall", 32'(bus.cpu_stall_o), 32'h1);
        chk("c4_addr",  bus.mem_addr_o,       DMA_ADDR);
        next();
        chk("c5_ack",   32'(bus.dma_ack_o),   32'h1);
        chk("c5_ddata", bus.dma_data_o,       32'h1122_3344);
        chk("c5_gnt",   32'(bus.dma_gnt_o),   32'h1);

        // Burst limit: grants 3..8 of the burst, then the CPU gets back in
        for (int c = 6; c <= 11; c++) begin
            next();
            chk("burst_gnt", 32'(bus.dma_gnt_o), 32'h1);
        end
        next();
        chk("c12_gnt",   32'(bus.dma_gnt_o),   32'h0);
        chk("c12_stall", 32'(bus.cpu_stall_o), 32'h0);
        chk("c12_ack",   32'(bus.dma_ack_o),   32'h1);
        next();
        chk("c13_ack", 32'(bus.dma_ack_o), 32'h0);
        chk("c13_gnt", 32'(bus.dma_gnt_o), 32'h0);
        for (int c = 14; c <= 15; c++) begin
            next();
            chk("rewait_gnt", 32'(bus.dma_gnt_o), 32'h0);
        end
        next();
        chk("c16_gnt", 32'(bus.dma_gnt_o), 32'h1);

        // Idle
        next();
        chk("c17_ack", 32'(bus.dma_ack_o), 32'h1);
        bus.cpu_req_i = 1'b0;
        bus.dma_req_i = 1'b0;
        #1;
        chk("idle_cs_n", 32'(bus.mem_cs_n_o), 32'h1);
        chk("idle_we_n", 32'(bus.mem_we_n_o), 32'hF);

        // CPU-only read, data held after request drops
        next();
        bus.cpu_req_i = 1'b1;
        #1;
        chk("rd_cs_n",  32'(bus.mem_cs_n_o),  32'h0);
        chk("rd_addr",  bus.mem_addr_o,       CPU_ADDR);
        chk("rd_stall", 32'(bus.cpu_stall_o), 32'h0);
        next();
        bus.cpu_req_i = 1'b0;
        #1;
        chk("rd_data", bus.cpu_data_o, 32'hDEAD_BEEF);
        next();
        chk("rd_hold", bus.cpu_data_o, 32'hDEAD_BEEF);

        // DMA byte-lane write, then CPU reads the word back
        bus.dma_req_i  = 1'b1;
        bus.dma_addr_i = CPU_ADDR;
        bus.dma_data_i = 32'h0000_AB00;
        bus.dma_we_i   = 4'b0010;
        #1;
        chk("wr_gnt",   32'(bus.dma_gnt_o),   32'h1);
        chk("wr_we_n",  32'(bus.mem_we_n_o),  32'hD);
        chk("wr_cs_n",  32'(bus.mem_cs_n_o),  32'h0);
        chk("wr_wdata", bus.mem_data_o,       32'h0000_AB00);
        next();
        chk("wr_ack", 32'(bus.dma_ack_o), 32'h1);
        bus.dma_req_i = 1'b0;
        bus.dma_we_i  = '0;
        bus.cpu_req_i = 1'b1;
        #1;
        chk("rb_stall", 32'(bus.cpu_stall_o), 32'h0);
        next();
        bus.cpu_req_i = 1'b0;
        word = bus.cpu_data_o;
        chk("rb_byte1", 32'(word[15:8]), 32'hAB);
        chk("rb_word",  word,            32'hDEAD_ABEF);

        // DMA-only burst interrupted by reset on its third grant
        bus.dma_req_i  = 1'b1;
        bus.dma_addr_i = DMA_ADDR;
        #1;
        chk("mb_gnt1", 32'(bus.dma_gnt_o), 32'h1);
        next();
        chk("mb_gnt2", 32'(bus.dma_gnt_o), 32'h1);
        chk("mb_ack1", 32'(bus.dma_ack_o), 32'h1);
        next();
        rst           = 1'b1;
        bus.cpu_req_i = 1'b1;
        #1;
        chk("mb_rst_gnt",   32'(bus.dma_gnt_o),   32'h0);
        chk("mb_rst_ack",   32'(bus.dma_ack_o),   32'h0);
        chk("mb_rst_cs_n",  32'(bus.mem_cs_n_o),  32'h1);
        chk("mb_rst_stall", 32'(bus.cpu_stall_o), 32'h0);
        next();
        rst = 1'b0;
        #1;
        chk("mb_post_ack",   32'(bus.dma_ack_o),   32'h0);
        chk("mb_post_gnt",   32'(bus.dma_gnt_o),   32'h0);
        chk("mb_post_stall", 32'(bus.cpu_stall_o), 32'h0);
        for (int c = 1; c <= 3; c++) begin
            next();
            chk("mb_wait_gnt", 32'(bus.dma_gnt_o), 32'h0);
        end
        next();
        chk("mb_forced_gnt", 32'(bus.dma_gnt_o), 32'h1);
        next();
        chk("mb_forced_gnt2", 32'(bus.dma_gnt_o), 32'h1);
        bus.cpu_req_i = 1'b0;
        bus.dma_req_i = 1'b0;
        next();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-ported byte-banked RAM (four 8-bit banks, 1-cycle read latency, active-low chip select and per-byte active-low write enables) between two masters: the HF-RISC core (master 0) and a DMA/external bus master (master 1).
- Sits between the RAM address-decode logic and the RAM banks.
- Drives the core's stall input whenever the core loses the port.
- CPU has default priority. DMA is protected from starvation by a wait counter and is bounded by a burst limit.

Parameters:
- ADDR_WIDTH, 32, width of address buses
- DATA_WIDTH, 32, width of data buses (4 byte lanes)
- MAX_WAIT, 4, cycles DMA may wait while CPU holds the port before DMA is forced in (>=1)
- MAX_BURST, 8, max consecutive DMA grants while CPU is requesting (>=1)

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, synchronous, active-high
- cpu_req_i  in  1  CPU RAM access valid (address decoded to RAM region)
- cpu_addr_i  in  ADDR_WIDTH  CPU address
- cpu_data_i  in  DATA_WIDTH  CPU write data
- cpu_we_i  in  4  CPU byte write enables, active-high
- cpu_stall_o  out  1  stall to core
- cpu_data_o  out  DATA_WIDTH  read data to core
- dma_req_i  in  1  DMA access request
- dma_addr_i  in  ADDR_WIDTH  DMA address
- dma_data_i  in  DATA_WIDTH  DMA write data
- dma_we_i  in  4  DMA byte write enables, active-high
- dma_gnt_o  out  1  DMA access accepted this cycle
- dma_ack_o  out  1  DMA access completed; read data valid
- dma_data_o  out  DATA_WIDTH  DMA read data
- mem_cs_n_o  out  1  RAM chip select, active-low
- mem_addr_o  out  ADDR_WIDTH  RAM address (banks use [15:2])
- mem_we_n_o  out  4  RAM byte write enables, active-low
- mem_data_o  out  DATA_WIDTH  RAM write data
- mem_data_i  in  DATA_WIDTH  RAM read data (valid cycle after access)

Behaviour:
- Reset state:
  - state=ST_CPU; wait_cnt=0; burst_cnt=0; owner_q=NONE; cpu_data_q=0.
  - While rst_i=1 the outputs are: mem_cs_n_o=1, mem_we_n_o=4'hF, cpu_stall_o=0, dma_gnt_o=0, dma_ack_o=0, dma_data_o=0, cpu_data_o=0.
  - Reset asserted mid-burst aborts it; no ack is issued for an access granted in the reset cycle.
- Grant logic is combinational from the registered state and counters, evaluated every cycle:
  - ST_CPU: grant DMA if dma_req_i & (!cpu_req_i | wait_cnt==MAX_WAIT). Otherwise grant CPU if cpu_req_i. Otherwise no grant.
  - ST_DMA: grant DMA if dma_req_i & (!cpu_req_i | burst_cnt<MAX_BURST). Otherwise grant CPU if cpu_req_i. Otherwise no grant.
- State transitions at clock edge:
  - DMA granted → ST_DMA; burst_cnt = (prev state ST_DMA ? burst_cnt+1 : 1), saturating at MAX_BURST.
  - Any cycle without a DMA grant → ST_CPU; burst_cnt=0.
  - burst_cnt counts only while cpu_req_i=1. If cpu_req_i=0 it holds, so a DMA-only burst is unbounded.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, when dma_req_i=1 and DMA is not granted.
  - Clears when DMA is granted or dma_req_i=0.
- Memory mux, granted master only:
  - mem_cs_n_o=0.
  - mem_addr_o and mem_data_o come from the granted master.
  - mem_we_n_o = ~we of the granted master.
  - With no grant: mem_cs_n_o=1, mem_we_n_o=4'hF, addr/data hold the CPU values.
- Handshake outputs:
  - cpu_stall_o = cpu_req_i & !cpu_grant.
  - dma_gnt_o = DMA grant (comb.). DMA must hold request/address/data until dma_gnt_o=1.
- Response path:
  - owner_q registers the granting master each cycle.
  - Cycle after a DMA grant: dma_ack_o=1 (registered) and dma_data_o=mem_data_i. Ack is issued for writes too.
  - Cycle after a CPU grant: cpu_data_o=mem_data_i and cpu_data_q captures it. Otherwise cpu_data_o=cpu_data_q.
- Back-to-back accesses: a new grant is allowed every cycle regardless of outstanding response, giving full throughput and 1-cycle latency for both masters.
- Simultaneous requests with wait_cnt<MAX_WAIT in ST_CPU: CPU wins.

Test Plan:
- Reset check: rst_i=1 for 2 cycles with both requests high → mem_cs_n_o=1, cpu_stall_o=0, dma_gnt_o=0. First cycle after release → CPU granted.
- CPU-only read, addr 0x40000010: mem_cs_n_o=0 same cycle, mem_addr_o=0x40000010, cpu_stall_o=0. RAM returns 0xDEADBEEF next cycle → cpu_data_o=0xDEADBEEF; held after cpu_req_i drops.
- Starvation (MAX_WAIT=4): cpu_req_i and dma_req_i held from cycle 0 → CPU granted cycles 0-3; cycle 4 dma_gnt_o=1 and cpu_stall_o=1; dma_ack_o=1 at cycle 5.
- Burst limit (MAX_BURST=8): DMA in ST_DMA, CPU requests continuously → 8 consecutive DMA grants, then CPU granted 1 cycle, state ST_CPU, wait_cnt counts again.
- DMA byte write: dma_we_i=4'b0010, data 0x0000AB00, CPU idle → mem_we_n_o=4'b1101 same cycle; dma_ack_o=1 next cycle. A CPU read of the same word returns byte1=0xAB.
- Reset mid-burst: assert rst_i in the 3rd DMA grant cycle → no dma_ack_o follows; after release state=ST_CPU and burst_cnt=0.
